// File: rtl/sobel_edge_sink_if.sv
// Stream bundle between the Sobel filter output stage and the edge sink.
// The master side drives the pixel beat (enable, frame start, magnitude, threshold).
// The slave side returns the qualified pixel, its coordinates and the frame status.
interface sobel_edge_sink_if;
  logic        control;
  logic        sof;
  logic [9:0]  pin;
  logic [9:0]  threshold;
  logic [7:0]  pout;
  logic        edge_flag;
  logic        pvalid;
  logic [10:0] px;
  logic [9:0]  py;
  logic        eof;
  logic        err;
  logic [15:0] frames;

  modport master (
    output control, sof, pin, threshold,
    input  pout, edge_flag, pvalid, px, py, eof, err, frames
  );

  modport slave (
    input  control, sof, pin, threshold,
    output pout, edge_flag, pvalid, px, py, eof, err, frames
  );
endinterface

// File: rtl/sobel_edge_sink.sv
// Consumer end of the Sobel pixel stream.
// Skips the filter's fixed line-buffer latency, re-attaches raster coordinates,
// blanks the window border, saturates the magnitude to 8 bits and thresholds it.
// Also produces end-of-frame pulses, a completed-frame count and a sticky
// protocol error flag. All outputs are registered.
module sobel_edge_sink #(
  parameter int SIZE_X  = 800,
  parameter int SIZE_Y  = 600,
  parameter int LATENCY = 804
) (
  input logic              clock,
  input logic              reset,
  sobel_edge_sink_if.slave sink
);

  localparam int FILL_W = $clog2(LATENCY + 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LATENCY);
  localparam logic [10:0]       X_LAST    = 11'(SIZE_X - 1);
  localparam logic [9:0]        Y_LAST    = 10'(SIZE_Y - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  // Clamp the 10-bit magnitude to the 8-bit display range.
  function automatic logic [7:0] saturate8(input logic [9:0] mag);
    logic [7:0] res;
    if (mag > 10'd255) begin
      res = 8'd255;
    end else begin
      res = mag[7:0];
    end
    return res;
  endfunction

  // The filter window is incomplete along the outer ring of the image.
  function automatic logic is_border(input logic [10:0] x, input logic [9:0] y);
    return (x == 11'd0) || (x == X_LAST) || (y == 10'd0) || (y == Y_LAST);
  endfunction

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [10:0]       cx_q, cx_d;      // column of the next pixel to emit
  logic [9:0]        cy_q, cy_d;      // row of the next pixel to emit
  logic [7:0]        pout_q, pout_d;
  logic              edge_q, edge_d;
  logic              pvalid_q, pvalid_d;
  logic [10:0]       px_q, px_d;
  logic [9:0]        py_q, py_d;
  logic              eof_q, eof_d;
  logic              err_q, err_d;
  logic [15:0]       frames_q, frames_d;

  logic              emit_s;          // this beat produces an output pixel
  logic [10:0]       ex_s;            // coordinates of the pixel emitted this beat
  logic [9:0]        ey_s;
  logic              last_s;          // emitted pixel closes the frame
  logic              at_last_s;       // stream is positioned on the final pixel

  // Next-state, coordinate and output computation for one beat.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    pout_d    = pout_q;
    edge_d    = edge_q;
    pvalid_d  = 1'b0;
    px_d      = px_q;
    py_d      = py_q;
    eof_d     = 1'b0;
    err_d     = err_q;
    frames_d  = frames_q;
    emit_s    = 1'b0;
    ex_s      = cx_q;
    ey_s      = cy_q;
    at_last_s = (cx_q == X_LAST) && (cy_q == Y_LAST);

    case (state_q)
      ST_IDLE: begin
        if (sink.control && sink.sof) begin
          state_d = ST_FILL;
          fill_d  = FILL_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (!sink.control) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sink.sof) begin
          // A new frame while the filter is still filling: drop the old one.
          err_d  = 1'b1;
          fill_d = FILL_ONE;
        end else if (fill_q == FILL_LAST) begin
          emit_s = 1'b1;
          ex_s   = 11'd0;
          ey_s   = 10'd0;
        end else begin
          fill_d = fill_q + FILL_ONE;
        end
      end

      ST_STREAM: begin
        if (!sink.control) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sink.sof && !at_last_s) begin
          // Early frame start abandons the current frame without emitting.
          err_d   = 1'b1;
          state_d = ST_FILL;
          fill_d  = FILL_ONE;
        end else begin
          emit_s = 1'b1;
          ex_s   = cx_q;
          ey_s   = cy_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    last_s = emit_s && (ex_s == X_LAST) && (ey_s == Y_LAST);

    if (emit_s) begin
      pvalid_d = 1'b1;
      px_d     = ex_s;
      py_d     = ey_s;
      if (is_border(ex_s, ey_s)) begin
        pout_d = 8'd0;
        edge_d = 1'b0;
      end else begin
        pout_d = saturate8(sink.pin);
        edge_d = (sink.pin >= sink.threshold);
      end

      if (last_s) begin
        eof_d    = 1'b1;
        frames_d = frames_q + 16'd1;
        cx_d     = 11'd0;
        cy_d     = 10'd0;
        // A frame start on the last-pixel beat chains straight into the next fill.
        if (sink.sof) begin
          state_d = ST_FILL;
          fill_d  = FILL_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d = ST_STREAM;
        if (ex_s == X_LAST) begin
          cx_d = 11'd0;
          cy_d = ey_s + 10'd1;
        end else begin
          cx_d = ex_s + 11'd1;
          cy_d = ey_s;
        end
      end
    end else begin
      pvalid_d = 1'b0;
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      cx_q     <= 11'd0;
      cy_q     <= 10'd0;
      pout_q   <= 8'd0;
      edge_q   <= 1'b0;
      pvalid_q <= 1'b0;
      px_q     <= 11'd0;
      py_q     <= 10'd0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      pout_q   <= pout_d;
      edge_q   <= edge_d;
      pvalid_q <= pvalid_d;
      px_q     <= px_d;
      py_q     <= py_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      frames_q <= frames_d;
    end
  end

  assign sink.pout      = pout_q;
  assign sink.edge_flag = edge_q;
  assign sink.pvalid    = pvalid_q;
  assign sink.px        = px_q;
  assign sink.py        = py_q;
  assign sink.eof       = eof_q;
  assign sink.err       = err_q;
  assign sink.frames    = frames_q;

endmodule

// File: tb/tb_sobel_edge_sink.sv
// Directed bench for sobel_edge_sink on a small 8x6 image with latency 12.
// Each cycle is compared against a beat-index reference; scenario end points
// are compared against hand-computed totals.
module tb_sobel_edge_sink;
  localparam int SX   = 8;
  localparam int SY   = 6;
  localparam int LAT  = 12;
  localparam int NPIX = SX * SY;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  sobel_edge_sink_if bus();

  sobel_edge_sink #(.SIZE_X(SX), .SIZE_Y(SY), .LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .sink  (bus)
  );

  int n_checks;
  int n_fail;

  // reference state: beats since the frame start beat
  logic        m_active;
  int          m_b;
  logic        e_pv, e_eof, e_err, e_edge;
  logic [15:0] e_frames;
  logic [10:0] e_px;
  logic [9:0]  e_py;
  logic [7:0]  e_pout;

  // per-scenario tallies taken from the DUT outputs
  int pv_seen, eof_seen, edge_seen, bord_seen, max_pout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pv_seen = 0; eof_seen = 0; edge_seen = 0; bord_seen = 0; max_pout = 0;
  endtask

  task automatic ref_emit(input int n, input logic [9:0] p, input logic [9:0] t);
    logic border;
    e_pv   = 1'b1;
    e_px   = 11'(n % SX);
    e_py   = 10'(n / SX);
    border = (e_px == 11'd0) || (e_px == 11'(SX - 1)) || (e_py == 10'd0) || (e_py == 10'(SY - 1));
    if (border) begin
      e_pout = 8'd0;
      e_edge = 1'b0;
    end else begin
      e_pout = (p > 10'd255) ? 8'd255 : p[7:0];
      e_edge = (p >= t);
    end
    if (n == NPIX - 1) begin
      e_eof    = 1'b1;
      e_frames = e_frames + 16'd1;
    end
  endtask

  // One clock: drive inputs, advance the reference, compare after the edge.
  task automatic cyc(input logic r, input logic c, input logic s,
                     input logic [9:0] p, input logic [9:0] t);
    int bb;
    reset         = r;
    bus.control   = c;
    bus.sof       = s;
    bus.pin       = p;
    bus.threshold = t;
    e_pv  = 1'b0;
    e_eof = 1'b0;
    if (r) begin
      m_active = 1'b0; m_b = 0;
      e_err = 1'b0; e_frames = 16'd0; e_px = 11'd0; e_py = 10'd0;
      e_pout = 8'd0; e_edge = 1'b0;
    end else if (c) begin
      if (m_active) begin
        bb = m_b + 1;
        if (s && (bb - LAT) != NPIX - 1) begin
          e_err = 1'b1;
          m_b   = 0;
        end else if (bb >= LAT) begin
          ref_emit(bb - LAT, p, t);
          if (bb - LAT == NPIX - 1) begin
            if (s) m_b = 0;
            else   m_active = 1'b0;
          end else begin
            m_b = bb;
          end
        end else begin
          m_b = bb;
        end
      end else if (s) begin
        m_active = 1'b1;
        m_b      = 0;
      end
    end else if (m_active) begin
      e_err    = 1'b1;
      m_active = 1'b0;
    end

    @(posedge clock);
    #1;
    chk("pvalid", 32'(bus.pvalid), 32'(e_pv));
    chk("eof",    32'(bus.eof),    32'(e_eof));
    chk("err",    32'(bus.err),    32'(e_err));
    chk("frames", 32'(bus.frames), 32'(e_frames));
    chk("px",     32'(bus.px),     32'(e_px));
    chk("py",     32'(bus.py),     32'(e_py));
    chk("pout",   32'(bus.pout),   32'(e_pout));
    chk("edge",   32'(bus.edge_flag), 32'(e_edge));
    if (bus.pvalid === 1'b1) begin
      pv_seen++;
      if (bus.edge_flag === 1'b1) edge_seen++;
      if (bus.pout === 8'd0 && bus.edge_flag === 1'b0) bord_seen++;
      if (int'(bus.pout) > max_pout) max_pout = int'(bus.pout);
    end
    if (bus.eof === 1'b1) eof_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
  endtask

  // A clean frame: frame start on beat 0, control held for all beats.
  task automatic run_frame(input logic [9:0] p, input logic [9:0] t);
    for (int b = 0; b < NPIX + LAT; b++) cyc(1'b0, 1'b1, (b == 0), p, t);
    idle(2);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_active = 1'b0; m_b = 0;
    e_err = 1'b0; e_frames = 16'd0; e_px = 11'd0; e_py = 10'd0;
    e_pout = 8'd0; e_edge = 1'b0; e_pv = 1'b0; e_eof = 1'b0;
    reset = 1'b1; bus.control = 1'b0; bus.sof = 1'b0; bus.pin = 10'd0; bus.threshold = 10'd0;
    clear_stats();

    // reset with random stimulus
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    chk("rst_frames", 32'(bus.frames), 32'd0);
    chk("rst_pout",   32'(bus.pout),   32'd0);

    // full frame
    clear_stats();
    for (int b = 0; b < 60; b++) begin
      cyc(1'b0, 1'b1, (b == 0), 10'd200, 10'd100);
      if (b == 11) chk("ff_no_early_pv", 32'(bus.pvalid), 32'd0);
      if (b == 12) chk("ff_first_pv",    32'(bus.pvalid), 32'd1);
      if (b == 59) begin
        chk("ff_eof_px", 32'(bus.px), 32'd7);
        chk("ff_eof_py", 32'(bus.py), 32'd5);
      end
    end
    idle(3);
    chk("ff_pv_cnt",   32'(pv_seen),   32'd48);
    chk("ff_edge_cnt", 32'(edge_seen), 32'd24);
    chk("ff_bord_cnt", 32'(bord_seen), 32'd24);
    chk("ff_max_pout", 32'(max_pout),  32'd200);
    chk("ff_eof_cnt",  32'(eof_seen),  32'd1);
    chk("ff_frames",   32'(bus.frames), 32'd1);
    chk("ff_err",      32'(bus.err),    32'd0);

    // saturation and threshold corners
    clear_stats();
    run_frame(10'd300, 10'd300);
    chk("sat300_edges", 32'(edge_seen), 32'd24);
    chk("sat300_max",   32'(max_pout),  32'd255);
    clear_stats();
    run_frame(10'd299, 10'd300);
    chk("sat299_edges", 32'(edge_seen), 32'd0);
    chk("sat299_max",   32'(max_pout),  32'd255);
    clear_stats();
    run_frame(10'd100, 10'd101);
    chk("thr101_edges", 32'(edge_seen), 32'd0);
    chk("thr101_max",   32'(max_pout),  32'd100);
    chk("sat_frames",   32'(bus.frames), 32'd4);

    // control drop mid-frame
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    clear_stats();
    for (int b = 0; b < 20; b++) cyc(1'b0, 1'b1, (b == 0), 10'd150, 10'd50);
    cyc(1'b0, 1'b0, 1'b0, 10'd150, 10'd50);
    chk("drop_err", 32'(bus.err), 32'd1);
    idle(8);
    chk("drop_pv_cnt", 32'(pv_seen),    32'd8);
    chk("drop_eof",    32'(eof_seen),   32'd0);
    chk("drop_frames", 32'(bus.frames), 32'd0);
    run_frame(10'd150, 10'd50);
    chk("drop_next_frames", 32'(bus.frames), 32'd1);
    chk("drop_err_sticky",  32'(bus.err),    32'd1);

    // back-to-back frames: second frame starts on the last-pixel beat
    cyc(1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
    clear_stats();
    for (int b = 0; b < 119; b++) begin
      cyc(1'b0, 1'b1, (b == 0 || b == 59), 10'd200, 10'd100);
      if (b == 59) chk("b2b_eof1",     32'(bus.eof),    32'd1);
      if (b == 70) chk("b2b_gap_pv",   32'(bus.pvalid), 32'd0);
      if (b == 71) chk("b2b_first_pv", 32'(bus.pvalid), 32'd1);
    end
    idle(2);
    chk("b2b_eof_cnt", 32'(eof_seen),   32'd2);
    chk("b2b_pv_cnt",  32'(pv_seen),    32'd96);
    chk("b2b_frames",  32'(bus.frames), 32'd2);
    chk("b2b_err",     32'(bus.err),    32'd0);

    // early frame start at beat 30 restarts the frame
    clear_stats();
    for (int b = 0; b < 30; b++) cyc(1'b0, 1'b1, (b == 0), 10'd200, 10'd100);
    cyc(1'b0, 1'b1, 1'b1, 10'd200, 10'd100);
    chk("early_err", 32'(bus.err), 32'd1);
    for (int b = 1; b < 60; b++) cyc(1'b0, 1'b1, 1'b0, 10'd200, 10'd100);
    idle(2);
    chk("early_pv_cnt", 32'(pv_seen),    32'd66);
    chk("early_eof",    32'(eof_seen),   32'd1);
    chk("early_frames", 32'(bus.frames), 32'd3);

    // reset in the middle of a frame
    clear_stats();
    for (int b = 0; b < 25; b++) cyc(1'b0, 1'b1, (b == 0), 10'd200, 10'd100);
    cyc(1'b1, 1'b1, 1'b0, 10'd200, 10'd100);
    chk("mrst_pvalid", 32'(bus.pvalid), 32'd0);
    chk("mrst_pout",   32'(bus.pout),   32'd0);
    chk("mrst_px",     32'(bus.px),     32'd0);
    chk("mrst_frames", 32'(bus.frames), 32'd0);
    chk("mrst_err",    32'(bus.err),    32'd0);
    run_frame(10'd200, 10'd100);
    chk("mrst_next_frames", 32'(bus.frames), 32'd1);
    chk("mrst_next_err",    32'(bus.err),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
